// File: rtl/keypad_scanner_n.sv
// Matrix keypad scanner: walks an active-low column, debounces per-frame results, emits keycode/valid/strobe/multi.
// Outputs update the cycle after the last-column tick of a committing frame; no backpressure, free-running scan.
module keypad_scanner_n #(
  parameter int NROWS    = 4,
  parameter int NCOLS    = 4,
  parameter int SCAN_DIV = 500000,
  parameter int DEBOUNCE = 2,
  localparam int KW      = $clog2(NROWS*NCOLS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NROWS-1:0]         row,
  output logic [NCOLS-1:0]         col,
  output logic [KW-1:0]            keycode,
  output logic                     keyvalid,
  output logic                     keystrobe,
  output logic                     multi,
  output logic [NROWS+NCOLS-1:0]   rawcode
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(NCOLS);
  localparam int SW = $clog2(DEBOUNCE+1);
  localparam int RW = 2 + KW;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV-1);
  localparam logic [CW-1:0] COL_LAST   = CW'(NCOLS-1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  logic [NROWS-1:0] row_s1, row_s2;
  logic [DW-1:0]    div_cnt;
  logic [CW-1:0]    col_idx, col_idx_nxt;
  logic [1:0]       acc_cnt, acc_cnt_nxt;
  logic [KW-1:0]    acc_code, acc_code_nxt;
  logic [RW-1:0]    frame_res, prev_res, prev_nxt, commit_res, commit_nxt;
  logic [SW-1:0]    stable_cnt, stable_nxt;
  logic             tick, frame_end;
  logic [1:0]       commit_kind, commit_nxt_kind;

  assign tick            = (div_cnt == DIV_LAST);
  assign frame_end       = tick && (col_idx == COL_LAST);
  assign col_idx_nxt     = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  assign commit_kind     = commit_res[RW-1 -: 2];
  assign commit_nxt_kind = commit_nxt[RW-1 -: 2];

  // Column 0 starts a fresh frame; the count saturates at 2 since only none/one/many matters.
  always_comb begin
    acc_cnt_nxt  = (col_idx == '0) ? 2'd0 : acc_cnt;
    acc_code_nxt = (col_idx == '0) ? '0   : acc_code;
    for (int r = 0; r < NROWS; r++) begin
      if (!row_s2[r]) begin
        if (acc_cnt_nxt == 2'd0)
          acc_code_nxt = KW'(r*NCOLS) + KW'(col_idx);
        if (acc_cnt_nxt != 2'd2)
          acc_cnt_nxt = acc_cnt_nxt + 2'd1;
      end
    end
  end

  // Code field is zeroed for NONE/MULTI so whole-word compares are meaningful.
  always_comb begin
    frame_res = {RES_NONE, {KW{1'b0}}};
    if (acc_cnt_nxt == 2'd1)
      frame_res = {RES_KEY, acc_code_nxt};
    else if (acc_cnt_nxt == 2'd2)
      frame_res = {RES_MULTI, {KW{1'b0}}};
  end

  always_comb begin
    prev_nxt   = prev_res;
    stable_nxt = stable_cnt;
    commit_nxt = commit_res;
    if (frame_end) begin
      if (frame_res == prev_res) begin
        if (stable_cnt != STABLE_MAX)
          stable_nxt = stable_cnt + 1'b1;
      end else begin
        prev_nxt   = frame_res;
        stable_nxt = SW'(1);
      end
      if (stable_nxt == STABLE_MAX && frame_res != commit_res)
        commit_nxt = frame_res;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1     <= '1;
      row_s2     <= '1;
      div_cnt    <= '0;
      col_idx    <= '0;
      col        <= ~NCOLS'(1);
      acc_cnt    <= 2'd0;
      acc_code   <= '0;
      prev_res   <= {RES_NONE, {KW{1'b0}}};
      commit_res <= {RES_NONE, {KW{1'b0}}};
      stable_cnt <= STABLE_MAX;
      keycode    <= '0;
      keyvalid   <= 1'b0;
      keystrobe  <= 1'b0;
      multi      <= 1'b0;
      rawcode    <= {{NROWS{1'b1}}, ~NCOLS'(1)};
    end else begin
      row_s1  <= row;
      row_s2  <= row_s1;
      rawcode <= {row_s2, col};
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        col_idx  <= col_idx_nxt;
        col      <= ~(NCOLS'(1) << col_idx_nxt);
        acc_cnt  <= acc_cnt_nxt;
        acc_code <= acc_code_nxt;
      end
      prev_res   <= prev_nxt;
      stable_cnt <= stable_nxt;
      commit_res <= commit_nxt;
      // Outputs follow the commit decision on the same edge to avoid an extra cycle of lag.
      keyvalid  <= (commit_nxt_kind == RES_KEY);
      multi     <= (commit_nxt_kind == RES_MULTI);
      keystrobe <= (commit_nxt != commit_res) && (commit_nxt_kind == RES_KEY) &&
                   (commit_kind == RES_NONE);
      if ((commit_nxt != commit_res) && (commit_nxt_kind == RES_KEY))
        keycode <= commit_nxt[KW-1:0];
    end
  end

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Directed bench for keypad_scanner_n with a 4x4 keypad model and hand-computed expectations.
module tb_keypad_scanner_n;

  logic       clock;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keycode;
  logic       keyvalid;
  logic       keystrobe;
  logic       multi;
  logic [7:0] rawcode;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int strobe_run = 0;
  int strobe_max_run = 0;

  keypad_scanner_n #(
    .NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE(2)
  ) dut (
    .clock(clock), .reset(reset), .row(row), .col(col), .keycode(keycode),
    .keyvalid(keyvalid), .keystrobe(keystrobe), .multi(multi), .rawcode(rawcode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col[c] == 1'b0))
          row[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (keystrobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_run = strobe_run + 1;
      if (strobe_run > strobe_max_run) strobe_max_run = strobe_run;
    end else begin
      strobe_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // sel 0 waits on keyvalid, sel 1 on multi; bounded by limit cycles.
  task automatic wait_for(input int sel, input logic want, input int limit);
    int n;
    n = 0;
    while (((sel == 0) ? keyvalid : multi) !== want && n < limit) begin
      step(1);
      n++;
    end
  endtask

  int base;
  logic kv_seen;

  initial begin
    reset = 1'b1;
    keys  = 16'h0000;
    step(3);
    check("rst_col", {28'd0, col}, 32'he);
    check("rst_keycode", {28'd0, keycode}, 32'd0);
    check("rst_keyvalid", {31'd0, keyvalid}, 32'd0);
    check("rst_multi", {31'd0, multi}, 32'd0);
    check("rst_keystrobe", {31'd0, keystrobe}, 32'd0);
    check("rst_rawcode", {24'd0, rawcode}, 32'hfe);
    reset = 1'b0;

    // Idle column walk, one step per 4 cycles.
    step(3);
    check("col_hold", {28'd0, col}, 32'he);
    step(1);
    check("col_step1", {28'd0, col}, 32'hd);
    step(4);
    check("col_step2", {28'd0, col}, 32'hb);
    step(4);
    check("col_step3", {28'd0, col}, 32'h7);
    step(4);
    check("col_wrap", {28'd0, col}, 32'he);
    step(32);
    check("idle_strobes", strobe_cnt, 0);
    check("idle_keyvalid", {31'd0, keyvalid}, 32'd0);

    // Hold (2,1) -> code 9.
    base = strobe_cnt;
    keys = 16'h0200;
    wait_for(0, 1'b1, 51);
    check("press9_valid", {31'd0, keyvalid}, 32'd1);
    check("press9_code", {28'd0, keycode}, 32'd9);
    step(2);
    check("press9_strobe", strobe_cnt - base, 1);
    step(160);
    check("hold9_strobe", strobe_cnt - base, 1);
    check("hold9_valid", {31'd0, keyvalid}, 32'd1);

    // Release, then press (0,3) -> code 3.
    keys = 16'h0000;
    wait_for(0, 1'b0, 51);
    check("rel9_valid", {31'd0, keyvalid}, 32'd0);
    check("rel9_code", {28'd0, keycode}, 32'd9);
    step(16);
    base = strobe_cnt;
    keys = 16'h0008;
    wait_for(0, 1'b1, 51);
    check("press3_valid", {31'd0, keyvalid}, 32'd1);
    check("press3_code", {28'd0, keycode}, 32'd3);
    step(32);
    check("press3_strobe", strobe_cnt - base, 1);

    // Bounce (1,2) for alternate frames only.
    keys = 16'h0000;
    wait_for(0, 1'b0, 51);
    check("rel3_valid", {31'd0, keyvalid}, 32'd0);
    step(32);
    base = strobe_cnt;
    kv_seen = 1'b0;
    for (int f = 0; f < 8; f++) begin
      keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
      for (int k = 0; k < 16; k++) begin
        step(1);
        if (keyvalid === 1'b1) kv_seen = 1'b1;
      end
    end
    keys = 16'h0000;
    step(48);
    check("bounce_strobe", strobe_cnt - base, 0);
    check("bounce_valid", {31'd0, kv_seen}, 32'd0);
    check("bounce_code", {28'd0, keycode}, 32'd3);

    // Chord (1,0)+(3,3), then release (1,0) -> code 15, no strobe.
    base = strobe_cnt;
    keys = 16'h8010;
    wait_for(1, 1'b1, 51);
    check("chord_multi", {31'd0, multi}, 32'd1);
    check("chord_valid", {31'd0, keyvalid}, 32'd0);
    check("chord_code", {28'd0, keycode}, 32'd3);
    keys = 16'h8000;
    wait_for(0, 1'b1, 51);
    check("unchord_valid", {31'd0, keyvalid}, 32'd1);
    check("unchord_multi", {31'd0, multi}, 32'd0);
    check("unchord_code", {28'd0, keycode}, 32'd15);
    step(32);
    check("chord_strobe", strobe_cnt - base, 0);

    // Hold (3,2), reset mid-operation, expect a single re-detection.
    keys = 16'h0000;
    wait_for(0, 1'b0, 51);
    step(32);
    keys = 16'h4000;
    wait_for(0, 1'b1, 51);
    check("pre_rst_code", {28'd0, keycode}, 32'd14);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_col", {28'd0, col}, 32'he);
    check("mid_rst_code", {28'd0, keycode}, 32'd0);
    check("mid_rst_valid", {31'd0, keyvalid}, 32'd0);
    check("mid_rst_multi", {31'd0, multi}, 32'd0);
    check("mid_rst_strobe", {31'd0, keystrobe}, 32'd0);
    base = strobe_cnt;
    wait_for(0, 1'b1, 51);
    check("redetect_valid", {31'd0, keyvalid}, 32'd1);
    check("redetect_code", {28'd0, keycode}, 32'd14);
    step(64);
    check("redetect_strobe", strobe_cnt - base, 1);
    check("strobe_width", strobe_max_run, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
